// File: rtl/arm_pkg.sv
// Shared fetch/decode types and constants.
package arm_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] ARM_NOP = 32'hE1A00000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// Fetch queue entry array: sync write port, async read port.
module fetch_queue_storage
  import arm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fetch_entry_t             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fetch_entry_t             rdata
);

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF->ID fetch queue; FETCH_QUEUE_BYPASS_EN enables
// zero-latency pass-through when empty.
module if_id_fetch_queue
  import arm_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WORD_W = arm_pkg::WORD_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WORD_W-1:0]          in_pc,
  input  logic [WORD_W-1:0]          in_instruction,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WORD_W-1:0]          out_pc,
  output logic [WORD_W-1:0]          out_instruction,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic         empty, full;
  logic         byp, consumed;
  logic         pop, wr_en;
  fetch_entry_t wr_entry, rd_entry;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = empty & in_valid & ~flush;
`else
  assign byp = 1'b0;
`endif

  assign in_ready  = ~full;
  assign out_valid = ~empty | byp;
  assign out_pc    = byp ? in_pc : rd_entry.pc;
  assign out_instruction =
    byp ? in_instruction : rd_entry.instruction;

  // A bypassed entry taken by decode never touches storage.
  assign consumed = byp & out_ready;
  assign wr_en    = in_valid & in_ready & ~flush & ~consumed;
  assign pop      = ~empty & out_ready & ~flush;

  assign wr_entry.pc          = in_pc;
  assign wr_entry.instruction = in_instruction;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;

  fetch_queue_storage #(
    .DEPTH(DEPTH)
  ) u_storage (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_en),
    .waddr(wr_ptr_q),
    .wdata(wr_entry),
    .raddr(rd_ptr_q),
    .rdata(rd_entry)
  );

endmodule
